// File: rtl/raw8_demosaic_2x2_if.sv
// Pixel stream bundle between the CSI-2 RAW8 receiver and the demosaic stage.
interface raw8_demosaic_2x2_if;
    logic        fv_in;
    logic        lv_in;
    logic [7:0]  din;
    logic [23:0] rgb;
    logic        fv_out;
    logic        lv_out;
    logic        line_ovf;

    // Source side: drives the Bayer stream and observes the RGB result.
    modport master (
        output fv_in, lv_in, din,
        input  rgb, fv_out, lv_out, line_ovf
    );

    // Demosaic side: consumes the Bayer stream and produces RGB888.
    modport slave (
        input  fv_in, lv_in, din,
        output rgb, fv_out, lv_out, line_ovf
    );
endinterface

// File: rtl/raw8_demosaic_2x2.sv
// 2x2 Bayer demosaic: RAW8 stream in, RGB888 out, two clocks of latency.
// One line buffer supplies the above / above-left neighbours.
module raw8_demosaic_2x2 #(
    parameter int unsigned LINE_MAX = 1920,
    parameter int unsigned BAYER    = 0,
    parameter int unsigned XW       = 11
) (
    input  logic               clk,
    input  logic               rstn,
    raw8_demosaic_2x2_if.slave vid
);
    // One spare bit so x can rest at LINE_MAX even when LINE_MAX == 2**XW.
    localparam int unsigned   CW    = XW + 1;
    localparam int unsigned   AW    = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
    localparam logic [CW-1:0] X_SAT = CW'(LINE_MAX);
    localparam logic [1:0]    PH0   = 2'(BAYER);

    logic          v;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [CW-1:0] x_q;
    logic [XW-1:0] y_q;

    logic [7:0]    line_mem [LINE_MAX];

    logic [7:0]    cur_q;
    logic [7:0]    left_q;
    logic [7:0]    above_q;
    logic [7:0]    above_left_q;
    logic [CW-1:0] x1_q;
    logic [XW-1:0] y1_q;
    logic          v1_q;
    logic          fv1_q;

    logic [1:0]    phase;
    logic          edge_px;
    logic [8:0]    g_sum;
    logic [7:0]    r_px;
    logic [7:0]    g_px;
    logic [7:0]    b_px;

    logic [23:0]   rgb_q;
    logic          fv_q;
    logic          lv_q;
    logic          ovf_q;

    assign v     = vid.fv_in & vid.lv_in;
    assign wr_en = v & (x_q < X_SAT);
    assign addr  = AW'(x_q);

    // Pixel / line position of the incoming sample.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (!v) begin
                x_q <= '0;
            end else if (x_q != X_SAT) begin
                x_q <= x_q + CW'(1);
            end
            if (!vid.fv_in) begin
                y_q <= '0;
            end else if (v1_q && !v) begin
                y_q <= y_q + XW'(1);
            end
        end
    end

    // Line buffer storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            line_mem[addr] <= vid.din;
        end
    end

    // Registered read-before-write port: returns the previous line's pixel.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            above_q <= '0;
        end else if (wr_en) begin
            above_q <= line_mem[addr];
        end
    end

    // Stage 1: 2x2 window and position of the pixel being coloured.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_q        <= '0;
            left_q       <= '0;
            above_left_q <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            v1_q         <= 1'b0;
            fv1_q        <= 1'b0;
        end else begin
            cur_q        <= vid.din;
            left_q       <= cur_q;
            above_left_q <= above_q;
            x1_q         <= x_q;
            y1_q         <= y_q;
            v1_q         <= v;
            fv1_q        <= vid.fv_in;
        end
    end

    // Sticky overflow flag, rearmed at each frame start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else if (vid.fv_in && !fv1_q) begin
            ovf_q <= 1'b0;
        end else if (v && !wr_en) begin
            ovf_q <= 1'b1;
        end
    end

    // Colour selection from the window by CFA phase of the current pixel.
    always_comb begin
        phase   = {y1_q[0], x1_q[0]} ^ PH0;
        edge_px = (x1_q == '0) || (y1_q == '0) || (x1_q >= X_SAT);
        r_px    = cur_q;
        b_px    = cur_q;
        g_sum   = {1'b0, left_q} + {1'b0, above_q};
        case (phase)
            2'd0: begin
                r_px  = cur_q;
                b_px  = above_left_q;
                g_sum = {1'b0, left_q} + {1'b0, above_q};
            end
            2'd1: begin
                r_px  = left_q;
                b_px  = above_q;
                g_sum = {1'b0, cur_q} + {1'b0, above_left_q};
            end
            2'd2: begin
                r_px  = above_q;
                b_px  = left_q;
                g_sum = {1'b0, cur_q} + {1'b0, above_left_q};
            end
            default: begin
                r_px  = above_left_q;
                b_px  = cur_q;
                g_sum = {1'b0, left_q} + {1'b0, above_q};
            end
        endcase
        g_px = g_sum[8:1];
    end

    // Stage 2: registered RGB and timing outputs; grey on edges, zero in blanking.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rgb_q <= '0;
            lv_q  <= 1'b0;
            fv_q  <= 1'b0;
        end else begin
            lv_q <= v1_q;
            fv_q <= fv1_q;
            if (!v1_q) begin
                rgb_q <= '0;
            end else if (edge_px) begin
                rgb_q <= {cur_q, cur_q, cur_q};
            end else begin
                rgb_q <= {r_px, g_px, b_px};
            end
        end
    end

    assign vid.rgb      = rgb_q;
    assign vid.fv_out   = fv_q;
    assign vid.lv_out   = lv_q;
    assign vid.line_ovf = ovf_q;

endmodule

// File: tb/tb_raw8_demosaic_2x2.sv
// Directed and randomised checks of raw8_demosaic_2x2 across all CFA phases.
`timescale 1ns/1ps
module tb_raw8_demosaic_2x2;
    localparam int LOGN = 8192;
    localparam int ND   = 5;   // 0..3: BAYER 0..3, 4: LINE_MAX=8 BAYER 0

    logic       clk = 1'b0;
    logic       rstn;
    logic       fv_r;
    logic       lv_r;
    logic [7:0] din_r;

    raw8_demosaic_2x2_if bus0 ();
    raw8_demosaic_2x2_if bus1 ();
    raw8_demosaic_2x2_if bus2 ();
    raw8_demosaic_2x2_if bus3 ();
    raw8_demosaic_2x2_if bus4 ();

    assign {bus0.fv_in, bus0.lv_in, bus0.din} = {fv_r, lv_r, din_r};
    assign {bus1.fv_in, bus1.lv_in, bus1.din} = {fv_r, lv_r, din_r};
    assign {bus2.fv_in, bus2.lv_in, bus2.din} = {fv_r, lv_r, din_r};
    assign {bus3.fv_in, bus3.lv_in, bus3.din} = {fv_r, lv_r, din_r};
    assign {bus4.fv_in, bus4.lv_in, bus4.din} = {fv_r, lv_r, din_r};

    raw8_demosaic_2x2 #(.BAYER(0)) u_b0 (.clk(clk), .rstn(rstn), .vid(bus0));
    raw8_demosaic_2x2 #(.BAYER(1)) u_b1 (.clk(clk), .rstn(rstn), .vid(bus1));
    raw8_demosaic_2x2 #(.BAYER(2)) u_b2 (.clk(clk), .rstn(rstn), .vid(bus2));
    raw8_demosaic_2x2 #(.BAYER(3)) u_b3 (.clk(clk), .rstn(rstn), .vid(bus3));
    raw8_demosaic_2x2 #(.LINE_MAX(8), .BAYER(0)) u_ovf (.clk(clk), .rstn(rstn), .vid(bus4));

    always #5 clk = ~clk;

    logic [23:0] rgb_log [ND][LOGN];
    logic        fv_log  [ND][LOGN];
    logic        lv_log  [ND][LOGN];
    logic        ovf_log [ND][LOGN];
    logic        fv_drv  [LOGN];
    logic        lv_drv  [LOGN];
    logic [7:0]  img     [16][64];
    int          pix_cyc [16][64];
    int          cyc;
    int          frame_start;
    int          n_tests;
    int          n_fail;

    // One clock: sample outputs at the falling edge, then drive the next inputs.
    task automatic tick(input logic f, input logic l, input logic [7:0] d);
        @(negedge clk);
        if (cyc >= LOGN) begin
            $display("FAIL log_depth: cycle %0d, limit %0d", cyc, LOGN);
            $fatal(1);
        end
        {rgb_log[0][cyc], fv_log[0][cyc], lv_log[0][cyc], ovf_log[0][cyc]} = {bus0.rgb, bus0.fv_out, bus0.lv_out, bus0.line_ovf};
        {rgb_log[1][cyc], fv_log[1][cyc], lv_log[1][cyc], ovf_log[1][cyc]} = {bus1.rgb, bus1.fv_out, bus1.lv_out, bus1.line_ovf};
        {rgb_log[2][cyc], fv_log[2][cyc], lv_log[2][cyc], ovf_log[2][cyc]} = {bus2.rgb, bus2.fv_out, bus2.lv_out, bus2.line_ovf};
        {rgb_log[3][cyc], fv_log[3][cyc], lv_log[3][cyc], ovf_log[3][cyc]} = {bus3.rgb, bus3.fv_out, bus3.lv_out, bus3.line_ovf};
        {rgb_log[4][cyc], fv_log[4][cyc], lv_log[4][cyc], ovf_log[4][cyc]} = {bus4.rgb, bus4.fv_out, bus4.lv_out, bus4.line_ovf};
        fv_r        = f;
        lv_r        = l;
        din_r       = d;
        fv_drv[cyc] = f;
        lv_drv[cyc] = f & l;
        cyc++;
    endtask

    // Frame of w x h pixels from img, with gap blanking cycles after each line.
    task automatic send_frame(input int w, input int h, input int gap);
        frame_start = cyc;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                pix_cyc[y][x] = cyc;
                tick(1'b1, 1'b1, img[y][x]);
            end
            for (int g = 0; g < gap; g++) tick(1'b1, 1'b0, 8'h00);
        end
        repeat (4) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic set_rows4(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        img[0][0] = a0; img[0][1] = a1; img[0][2] = a2; img[0][3] = a3;
        img[1][0] = b0; img[1][1] = b1; img[1][2] = b2; img[1][3] = b3;
    endtask

    // Reference: classify each window site by its own CFA colour.
    function automatic logic [23:0] ref_rgb(input int xx, input int yy, input int bayer);
        logic [7:0] r;
        logic [7:0] b;
        logic [7:0] px;
        int         gs;
        int         c;
        if (xx == 0 || yy == 0) return {img[yy][xx], img[yy][xx], img[yy][xx]};
        r  = 8'h00;
        b  = 8'h00;
        gs = 0;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                px = img[yy-dy][xx-dx];
                c  = ((((yy - dy) % 2) * 2) + ((xx - dx) % 2)) ^ bayer;
                if (c == 0)      r = px;
                else if (c == 3) b = px;
                else             gs += int'(px);
            end
        end
        return {r, 8'(gs / 2), b};
    endfunction

    task automatic test_reset();
        int k;
        rstn = 1'b0;
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        k = cyc - 1;
        for (int d = 0; d < ND; d++) begin
            n_tests++;
            if ({rgb_log[d][k], fv_log[d][k], lv_log[d][k], ovf_log[d][k]} !== 27'h0) begin
                n_fail++;
                $display("FAIL reset_dut%0d: rgb=%h fv=%b lv=%b ovf=%b, want all zero",
                         d, rgb_log[d][k], fv_log[d][k], lv_log[d][k], ovf_log[d][k]);
            end
        end
        rstn = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_rggb();
        int          xs [9] = '{0, 1, 3, 0, 1, 2, 3, 1, 2};
        int          ys [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
        int          ds [9] = '{0, 0, 0, 0, 0, 0, 0, 3, 3};
        logic [23:0] ex [9] = '{24'h0A0A0A, 24'h141414, 24'h282828, 24'h323232, 24'h0A233C,
                                24'h1E2D3C, 24'h1E3750, 24'h3C230A, 24'h3C2D1E};
        logic [23:0] got;
        set_rows4(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80);
        send_frame(4, 2, 2);
        for (int i = 0; i < 9; i++) begin
            got = rgb_log[ds[i]][pix_cyc[ys[i]][xs[i]] + 2];
            n_tests++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL rggb_dut%0d_px%0d_%0d: got %h want %h", ds[i], xs[i], ys[i], got, ex[i]);
            end
        end
    endtask

    // Uses the frame just sent by test_rggb; observed on the BGGR instance.
    task automatic test_latency();
        int   at  [7];
        logic exl [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        at[0] = pix_cyc[0][0] + 1;
        at[1] = pix_cyc[0][0] + 2;
        at[2] = pix_cyc[0][3] + 2;
        at[3] = pix_cyc[0][3] + 3;
        at[4] = pix_cyc[1][0] + 1;
        at[5] = pix_cyc[1][0] + 2;
        at[6] = pix_cyc[1][3] + 2;
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (lv_log[3][at[i]] !== exl[i]) begin
                n_fail++;
                $display("FAIL latency_lv_%0d: got %b want %b", i, lv_log[3][at[i]], exl[i]);
            end
        end
        n_tests++;
        if ({fv_log[3][frame_start + 1], fv_log[3][frame_start + 2]} !== 2'b01) begin
            n_fail++;
            $display("FAIL latency_fv_rise: got %b%b want 01", fv_log[3][frame_start + 1], fv_log[3][frame_start + 2]);
        end
        n_tests++;
        if (rgb_log[3][pix_cyc[0][3] + 3] !== 24'h0) begin
            n_fail++;
            $display("FAIL blank_rgb: got %h want 000000", rgb_log[3][pix_cyc[0][3] + 3]);
        end
    endtask

    task automatic test_reset_midline();
        int          r0;
        int          xs [5] = '{0, 1, 3, 1, 2};
        int          ys [5] = '{0, 0, 0, 1, 1};
        logic [23:0] ex [5] = '{24'hC9C9C9, 24'hFAFAFA, 24'h828282, 24'hC9F5FF, 24'h78CDFF};
        logic [23:0] got;
        tick(1'b1, 1'b0, 8'h00);
        for (int x = 0; x < 3; x++) tick(1'b1, 1'b1, img[0][x]);
        rstn = 1'b0;
        r0 = cyc;
        repeat (3) tick(1'b1, 1'b1, 8'h55);
        rstn = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        n_tests++;
        if (lv_log[0][r0 - 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_lv: got %b want 1", lv_log[0][r0 - 1]);
        end
        for (int k = r0; k < r0 + 3; k++) begin
            for (int d = 0; d < ND; d++) begin
                n_tests++;
                if ({rgb_log[d][k], fv_log[d][k], lv_log[d][k], ovf_log[d][k]} !== 27'h0) begin
                    n_fail++;
                    $display("FAIL midline_reset_dut%0d_c%0d: rgb=%h fv=%b lv=%b want all zero",
                             d, k - r0, rgb_log[d][k], fv_log[d][k], lv_log[d][k]);
                end
            end
        end
        set_rows4(8'd201, 8'd250, 8'd120, 8'd130, 8'd240, 8'd255, 8'd160, 8'd170);
        send_frame(4, 2, 2);
        for (int i = 0; i < 5; i++) begin
            got = rgb_log[0][pix_cyc[ys[i]][xs[i]] + 2];
            n_tests++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL after_reset_px%0d_%0d: got %h want %h", xs[i], ys[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_fv_fall();
        int          f0;
        int          p0;
        int          xs [4] = '{0, 2, 1, 2};
        int          ys [4] = '{0, 0, 1, 1};
        logic [23:0] ex [4] = '{24'h646464, 24'h787878, 24'h647D96, 24'h788796};
        logic [23:0] got;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        for (int x = 0; x < 4; x++) tick(1'b1, 1'b1, 8'(5 + x));
        repeat (2) tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 8'd9);
        tick(1'b1, 1'b1, 8'd10);
        f0 = cyc;
        tick(1'b0, 1'b1, 8'h77);
        tick(1'b0, 1'b0, 8'h00);
        p0 = cyc;
        repeat (3) tick(1'b0, 1'b1, 8'hAA);
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        repeat (2) tick(1'b0, 1'b1, 8'hBB);
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        for (int k = f0 + 2; k < p0 + 10; k++) begin
            n_tests++;
            if ({rgb_log[0][k], fv_log[0][k], lv_log[0][k]} !== 26'h0) begin
                n_fail++;
                $display("FAIL fv_low_quiet_c%0d: rgb=%h fv=%b lv=%b want all zero",
                         k - f0, rgb_log[0][k], fv_log[0][k], lv_log[0][k]);
            end
        end
        set_rows4(8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170);
        send_frame(4, 2, 2);
        for (int i = 0; i < 4; i++) begin
            got = rgb_log[0][pix_cyc[ys[i]][xs[i]] + 2];
            n_tests++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL after_fv_fall_px%0d_%0d: got %h want %h", xs[i], ys[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int          xs [4] = '{1, 7, 8, 9};
        logic [23:0] ex [4] = '{24'h0B1016, 24'h11161C, 24'h1D1D1D, 24'h1E1E1E};
        logic [23:0] got;
        for (int x = 0; x < 10; x++) begin
            img[0][x] = 8'(11 + x);
            img[1][x] = 8'(21 + x);
        end
        send_frame(10, 2, 2);
        n_tests++;
        if (ovf_log[4][pix_cyc[0][8]] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_before_9th: got %b want 0", ovf_log[4][pix_cyc[0][8]]);
        end
        n_tests++;
        if (ovf_log[4][pix_cyc[0][8] + 2] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_on_9th: got %b want 1", ovf_log[4][pix_cyc[0][8] + 2]);
        end
        n_tests++;
        if (ovf_log[4][cyc - 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", ovf_log[4][cyc - 1]);
        end
        for (int i = 0; i < 4; i++) begin
            got = rgb_log[4][pix_cyc[1][xs[i]] + 2];
            n_tests++;
            if (got !== ex[i]) begin
                n_fail++;
                $display("FAIL ovf_px%0d_1: got %h want %h", xs[i], got, ex[i]);
            end
        end
        send_frame(8, 2, 2);
        n_tests++;
        if ({ovf_log[4][frame_start], ovf_log[4][frame_start + 1]} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_clear_on_fv_rise: got %b%b want 10",
                     ovf_log[4][frame_start], ovf_log[4][frame_start + 1]);
        end
        n_tests++;
        if (ovf_log[4][cyc - 1] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full_line: got %b want 0", ovf_log[4][cyc - 1]);
        end
    endtask

    task automatic test_random();
        logic [23:0] exp_rgb;
        logic [23:0] got;
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 64; x++) begin
                    img[y][x] = (f == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(200, 255));
                end
            end
            send_frame(64, 16, 3);
            for (int d = 0; d < 4; d++) begin
                for (int y = 0; y < 16; y++) begin
                    for (int x = 0; x < 64; x++) begin
                        exp_rgb = ref_rgb(x, y, d);
                        got     = rgb_log[d][pix_cyc[y][x] + 2];
                        n_tests++;
                        if (got !== exp_rgb) begin
                            n_fail++;
                            $display("FAIL rand_f%0d_dut%0d_px%0d_%0d: got %h want %h", f, d, x, y, got, exp_rgb);
                        end
                    end
                end
                for (int k = frame_start + 2; k < cyc; k++) begin
                    n_tests++;
                    if ({fv_log[d][k], lv_log[d][k]} !== {fv_drv[k - 2], lv_drv[k - 2]}) begin
                        n_fail++;
                        $display("FAIL rand_f%0d_dut%0d_timing_c%0d: fv/lv got %b%b want %b%b", f, d, k,
                                 fv_log[d][k], lv_log[d][k], fv_drv[k - 2], lv_drv[k - 2]);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        fv_r    = 1'b0;
        lv_r    = 1'b0;
        din_r   = 8'h00;
        test_reset();
        test_rggb();
        test_latency();
        test_reset_midline();
        test_fv_fall();
        test_overflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/raw8_demosaic_2x2.md
Name: raw8_demosaic_2x2

Overview:
- Downstream stage of the MIPI CSI-2 RAW8 receiver.
- Consumes the receiver's pixel-clock-domain RAW8 Bayer stream (8-bit pixel data, fv, lv) and produces 24-bit RGB888 plus delayed fv/lv for the HDMI output path.
- Uses a 2x2 demosaic with one line buffer: current pixel, left pixel, above pixel and above-left pixel.

Parameters:
- LINE_MAX, 1920: maximum pixels per line; sets line-buffer depth and x-counter range.
- BAYER, 0: CFA phase of pixel (0,0). 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
- XW, 11: x-counter width; must satisfy 2^XW >= LINE_MAX.

Ports:
- clk  input  1  pixel clock; the single clock of the block.
- rstn  input  1  synchronous reset, active-low.
- fv_in  input  1  frame valid (vs).
- lv_in  input  1  line valid (de); ignored while fv_in=0.
- din  input  8  RAW8 pixel, valid when fv_in&lv_in.
- rgb  output  24  {R[23:16],G[15:8],B[7:0]}.
- fv_out  output  1  fv_in delayed 2 clk.
- lv_out  output  1  qualified lv (fv_in&lv_in) delayed 2 clk.
- line_ovf  output  1  sticky: a line in the current frame exceeded LINE_MAX.

Behaviour:
- Reset (rstn=0 sampled at a clk edge) clears: rgb=0, fv_out=0, lv_out=0, line_ovf=0, x=0, y=0, all pipeline registers. Line-buffer RAM contents are not cleared.
- Qualified valid: v = fv_in & lv_in.
- Pixel/line counters:
  - x: cleared on every cycle with v=0; increments on each v=1 cycle; saturates at LINE_MAX.
  - y: cleared while fv_in=0; increments by 1 on the v falling edge (1->0 while fv_in=1).
- Line buffer: one RAM, LINE_MAX x 8, single clock. On v=1 with x<LINE_MAX it writes din at address x, and reads address x in the same cycle (read-before-write, registered output). The read returns the pixel from the previous line.
- Pipeline:
  - Stage 1 registers: din→cur, previous cur→left, RAM out→above, previous above→above_left, plus x, y, v, fv.
  - Stage 2 computes the colour and registers rgb, lv_out, fv_out.
  - Latency from din/fv_in/lv_in to rgb/fv_out/lv_out is exactly 2 clk.
- Colour assignment for x>=1 and y>=1:
  - Phase p = {y[0],x[0]} XOR the phase of BAYER.
  - The window holds exactly one R, one B and two G.
  - R and B are taken directly from their window positions.
  - G = (g_a + g_b) >> 1, computed with a 9-bit sum and truncated.
- Edge pixels (x==0 or y==0): rgb = {cur,cur,cur} (grey).
- When lv_out=0, rgb holds 0.
- Overflow: pixels at x>=LINE_MAX are not written to the RAM and produce rgb = {cur,cur,cur}. line_ovf sets on the first such pixel and clears on the fv_in rising edge.
- fv_in falling mid-line: acts as a line end. x clears, y clears, and the partial line is discarded from the buffer's point of view.
- lv_in high while fv_in low: no output activity; lv_out stays 0.
- Reset mid-frame: the next frame starts clean at the first fv_in rise. The y==0 row renders grey, so stale RAM data is never used.

Test Plan:
- RGGB phase (BAYER=0), 4x2 frame, row0 = 10,20,30,40 and row1 = 50,60,70,80:
  - Pixel (1,1) → rgb = {10,35,60}, i.e. 0x0A233C.
  - Pixel (2,1) → rgb = {30,45,60}.
  - All of row0 and pixel (0,1) are grey, e.g. pixel (0,0) → 0x0A0A0A.
- Same data with BAYER=3 (BGGR): pixel (1,1) → rgb = {60,35,10}. Latency check: lv_out rises exactly 2 clk after lv_in and falls 2 clk after lv_in falls.
- Reset: hold rstn=0 for 3 clk mid-line → all outputs 0 on the next edge. After release, the next frame's first row is grey.
- LINE_MAX=8 override, 10-pixel line → line_ovf=1 from the 9th pixel and stays set. It clears on the next fv_in rise; an 8-pixel line does not set it.
- lv_in pulses with fv_in=0 → lv_out=0, rgb=0, y stays 0. An fv_in fall mid-line, then a new frame → that frame's first row is grey.
- Random 64x16 frames for all four BAYER values, checked against a reference model with the same edge/truncation rules → bit-exact rgb, and fv_out/lv_out equal to the inputs delayed 2 clk.
